dco_update_seq: RTL and testbench

Glitch-safe update sequencer between the DCO configuration register block and the DCO macro. It takes the software-written DCO codes (coarse, fine, divider, frequency select), detects any change, and gates the DCO output clock before applying the new codes. It waits a fixed settle interval after applying them, then ungates the clock. Downstream logic never sees a clock edge produced while the DCO codes are in transition.

---
 rtl/dco_update_seq.sv | 113 +++++++++++
 tb/tb_dco_update_seq.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_update_seq.sv
// Glitch-safe DCO code update sequencer: gates the DCO output clock, applies
// the new codes, waits a settle interval and only then ungates the clock.
module dco_update_seq #(
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] cc_sel_i,
  input  logic [5:0] fc_sel_i,
  input  logic [2:0] div_sel_i,
  input  logic [1:0] freq_sel_i,
  output logic [5:0] cc_sel_o,
  output logic [5:0] fc_sel_o,
  output logic [2:0] div_sel_o,
  output logic [1:0] freq_sel_o,
  output logic       clk_en_o,
  output logic       busy_o,
  output logic [7:0] upd_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_APPLY,
    S_SETTLE
  } state_t;

  localparam logic [7:0] GATE_LOAD   = 8'(GATE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [5:0] r_cc;
  logic [5:0] r_fc;
  logic [2:0] r_div;
  logic [1:0] r_freq;
  logic       r_clk_en;
  logic       r_busy;
  logic [7:0] r_upd_cnt;
  logic       w_mismatch;
  logic       w_apply;

  assign w_mismatch = ({cc_sel_i, fc_sel_i, div_sel_i, freq_sel_i} !=
                       {r_cc, r_fc, r_div, r_freq});

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_apply     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mismatch) begin
          w_state_nxt = S_GATE;
          w_cnt_nxt   = GATE_LOAD;
        end
      end
      S_GATE: begin
        if (r_cnt == '0) w_state_nxt = S_APPLY;
        else             w_cnt_nxt   = r_cnt - 8'd1;
      end
      S_APPLY: begin
        w_apply     = 1'b1;
        w_cnt_nxt   = SETTLE_LOAD;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        // A pending change re-applies straight away: the clock is already gated.
        if (r_cnt == '0) w_state_nxt = w_mismatch ? S_APPLY : S_IDLE;
        else             w_cnt_nxt   = r_cnt - 8'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_SETTLE;
      r_cnt     <= SETTLE_LOAD;
      r_cc      <= 6'h3F;
      r_fc      <= 6'h3F;
      r_div     <= 3'b100;
      r_freq    <= 2'b11;
      r_clk_en  <= 1'b0;
      r_busy    <= 1'b1;
      r_upd_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Gate control comes straight from a flop so it cannot glitch on state decode.
      r_clk_en <= (w_state_nxt == S_IDLE);
      r_busy   <= (w_state_nxt != S_IDLE);
      if (w_apply) begin
        r_cc      <= cc_sel_i;
        r_fc      <= fc_sel_i;
        r_div     <= div_sel_i;
        r_freq    <= freq_sel_i;
        r_upd_cnt <= r_upd_cnt + 8'd1;
      end
    end
  end

  assign cc_sel_o   = r_cc;
  assign fc_sel_o   = r_fc;
  assign div_sel_o  = r_div;
  assign freq_sel_o = r_freq;
  assign clk_en_o   = r_clk_en;
  assign busy_o     = r_busy;
  assign upd_cnt_o  = r_upd_cnt;

endmodule

// File: tb/tb_dco_update_seq.sv
// Bench for dco_update_seq: default instance plus a GATE=1/SETTLE=1 instance,
// both compared every cycle against an event-time reference model.
`timescale 1ns/1ps
module tb_dco_update_seq;

  localparam int G0 = 4;
  localparam int S0 = 64;
  localparam int G1 = 1;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] cc_i = 6'h3F;
  logic [5:0] fc_i = 6'h3F;
  logic [2:0] div_i = 3'b100;
  logic [1:0] fq_i = 2'b11;

  logic [5:0] cc0, fc0, cc1, fc1;
  logic [2:0] div0, div1;
  logic [1:0] fq0, fq1;
  logic       en0, busy0, en1, busy1;
  logic [7:0] upd0, upd1;
  logic [26:0] got [2];

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  dco_update_seq #(.GATE_CYCLES(G0), .SETTLE_CYCLES(S0)) dut (
    .clk(clk), .rst(rst),
    .cc_sel_i(cc_i), .fc_sel_i(fc_i), .div_sel_i(div_i), .freq_sel_i(fq_i),
    .cc_sel_o(cc0), .fc_sel_o(fc0), .div_sel_o(div0), .freq_sel_o(fq0),
    .clk_en_o(en0), .busy_o(busy0), .upd_cnt_o(upd0)
  );

  dco_update_seq #(.GATE_CYCLES(G1), .SETTLE_CYCLES(S1)) dut_min (
    .clk(clk), .rst(rst),
    .cc_sel_i(cc_i), .fc_sel_i(fc_i), .div_sel_i(div_i), .freq_sel_i(fq_i),
    .cc_sel_o(cc1), .fc_sel_o(fc1), .div_sel_o(div1), .freq_sel_o(fq1),
    .clk_en_o(en1), .busy_o(busy1), .upd_cnt_o(upd1)
  );

  assign got[0] = {cc0, fc0, div0, fq0, en0, busy0, upd0};
  assign got[1] = {cc1, fc1, div1, fq1, en1, busy1, upd1};

  // Reference model: tracks the edge number at which codes are applied and
  // at which settling ends, rather than a state machine with a counter.
  logic [5:0] m_cc [2];
  logic [5:0] m_fc [2];
  logic [2:0] m_div [2];
  logic [1:0] m_fq [2];
  logic       m_en [2];
  logic [7:0] m_upd [2];
  int         m_cyc [2];
  int         m_apply_at [2];
  int         m_settle_end [2];

  function automatic int gcyc(int i);
    return (i == 0) ? G0 : G1;
  endfunction

  function automatic int scyc(int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic logic [26:0] exp_vec(int i);
    return {m_cc[i], m_fc[i], m_div[i], m_fq[i], m_en[i], ~m_en[i], m_upd[i]};
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic mm;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cc[i] = 6'h3F; m_fc[i] = 6'h3F; m_div[i] = 3'b100; m_fq[i] = 2'b11;
        m_en[i] = 1'b0; m_upd[i] = 8'd0; m_cyc[i] = 0;
        m_apply_at[i] = -1;
        m_settle_end[i] = scyc(i);
      end else begin
        m_cyc[i] += 1;
        mm = ({cc_i, fc_i, div_i, fq_i} != {m_cc[i], m_fc[i], m_div[i], m_fq[i]});
        if (m_en[i]) begin
          if (mm) begin
            m_en[i] = 1'b0;
            m_apply_at[i] = m_cyc[i] + gcyc(i) + 1;
          end
        end else if (m_cyc[i] == m_apply_at[i]) begin
          m_cc[i] = cc_i; m_fc[i] = fc_i; m_div[i] = div_i; m_fq[i] = fq_i;
          m_upd[i] = m_upd[i] + 8'd1;
          m_apply_at[i] = -1;
          m_settle_end[i] = m_cyc[i] + scyc(i);
        end else if (m_cyc[i] == m_settle_end[i]) begin
          m_settle_end[i] = -1;
          if (mm) m_apply_at[i] = m_cyc[i] + 1;
          else    m_en[i] = 1'b1;
        end
      end
    end
  end

  task automatic test_reset();
    int low0 = 0;
    int low1 = 0;
    logic [26:0] rv;
    rv = {6'h3F, 6'h3F, 3'b100, 2'b11, 1'b0, 1'b1, 8'h00};
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (got[i] !== rv) begin
          nmis++;
          $display("FAIL reset_value dut%0d: got %h expected %h", i, got[i], rv);
        end
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (got[i] !== exp_vec(i)) begin
          nmis++;
          $display("FAIL reset_seq dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
        end
      end
      if (!en0) low0++;
      if (!en1) low1++;
      @(negedge clk);
    end
    nvec++;
    if (low0 != 64) begin nmis++; $display("FAIL reset_gated_len dut0: got %0d expected 64", low0); end
    nvec++;
    if (low1 != 1) begin nmis++; $display("FAIL reset_gated_len dut1: got %0d expected 1", low1); end
  endtask

  task automatic test_single_update();
    int fall0 = -1, rise0 = -1, cc_at = -1, fall1 = -1, rise1 = -1;
    cc_i = 6'h20;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (got[i] !== exp_vec(i)) begin
          nmis++;
          $display("FAIL single dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
        end
      end
      if (!en0 && fall0 < 0) fall0 = k;
      if (cc0 == 6'h20 && cc_at < 0) cc_at = k;
      if (en0 && fall0 >= 0 && rise0 < 0) rise0 = k;
      if (!en1 && fall1 < 0) fall1 = k;
      if (en1 && fall1 >= 0 && rise1 < 0) rise1 = k;
    end
    nvec++;
    if (cc_at - fall0 != 5) begin nmis++; $display("FAIL single_apply_lat: got %0d expected 5", cc_at - fall0); end
    nvec++;
    if (rise0 - fall0 != 69) begin nmis++; $display("FAIL single_window dut0: got %0d expected 69", rise0 - fall0); end
    nvec++;
    if (rise1 - fall1 != 3) begin nmis++; $display("FAIL single_window dut1: got %0d expected 3", rise1 - fall1); end
    nvec++;
    if (upd0 !== 8'd1 || upd1 !== 8'd1) begin
      nmis++; $display("FAIL single_upd: got %0d/%0d expected 1/1", upd0, upd1);
    end
  endtask

  task automatic test_gate_absorb();
    logic [7:0] u0, u1;
    bit done = 0;
    u0 = m_upd[0];
    u1 = m_upd[1];
    fc_i = 6'h10;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (got[i] !== exp_vec(i)) begin
        nmis++;
        $display("FAIL gate_absorb dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
      end
    end
    fc_i = 6'h08;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (got[i] !== exp_vec(i)) begin
          nmis++;
          $display("FAIL gate_absorb dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
        end
      end
      if (en0 && en1) begin done = 1; break; end
    end
    nvec++;
    if (!done) begin nmis++; $display("FAIL gate_absorb_timeout: got busy expected idle"); end
    nvec++;
    if (fc0 !== 6'h08 || fc1 !== 6'h08) begin
      nmis++; $display("FAIL gate_absorb_fc: got %h/%h expected 08/08", fc0, fc1);
    end
    nvec++;
    if (upd0 !== 8'(u0 + 8'd1) || upd1 !== 8'(u1 + 8'd1)) begin
      nmis++; $display("FAIL gate_absorb_upd: got %0d/%0d expected %0d/%0d", upd0, upd1, u0 + 8'd1, u1 + 8'd1);
    end
  endtask

  task automatic test_settle_reapply();
    logic [7:0] u0, u1;
    int low0 = 0;
    bit done = 0;
    u0 = m_upd[0];
    u1 = m_upd[1];
    fq_i = 2'b01;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (got[i] !== exp_vec(i)) begin
          nmis++;
          $display("FAIL reapply dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
        end
      end
      if (!en0) low0++;
      if (k == 15) div_i = 3'b010;
      if (k > 15 && en0 && en1) begin done = 1; break; end
    end
    nvec++;
    if (!done) begin nmis++; $display("FAIL reapply_timeout: got busy expected idle"); end
    nvec++;
    if (low0 != 134) begin nmis++; $display("FAIL reapply_window: got %0d expected 134", low0); end
    nvec++;
    if (div0 !== 3'b010 || fq0 !== 2'b01) begin
      nmis++; $display("FAIL reapply_codes: got div %b fq %b expected 010 01", div0, fq0);
    end
    nvec++;
    if (upd0 !== 8'(u0 + 8'd2) || upd1 !== 8'(u1 + 8'd2)) begin
      nmis++; $display("FAIL reapply_upd: got %0d/%0d expected %0d/%0d", upd0, upd1, u0 + 8'd2, u1 + 8'd2);
    end
  endtask

  task automatic test_random();
    int wait_n;
    bit done = 0;
    for (int it = 0; it < 40; it++) begin
      wait_n = $urandom_range(0, 90);
      case ($urandom_range(0, 4))
        0: cc_i = 6'($urandom);
        1: fc_i = 6'($urandom);
        2: div_i = 3'($urandom);
        3: fq_i = 2'($urandom);
        default: cc_i = m_cc[0];
      endcase
      for (int k = 0; k <= wait_n; k++) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          nvec++;
          if (got[i] !== exp_vec(i)) begin
            nmis++;
            $display("FAIL random dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
          end
        end
      end
    end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (got[i] !== exp_vec(i)) begin
          nmis++;
          $display("FAIL random_drain dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
        end
      end
      if (en0 && en1) begin done = 1; break; end
    end
    nvec++;
    if (!done) begin nmis++; $display("FAIL random_timeout: got busy expected idle"); end
  endtask

  task automatic test_reset_in_settle();
    logic [26:0] rv;
    bit done = 0;
    int low0 = 0;
    int rise1 = -1;
    rv = {6'h3F, 6'h3F, 3'b100, 2'b11, 1'b0, 1'b1, 8'h00};
    cc_i = 6'h3F; fc_i = 6'h3F; div_i = 3'b100; fq_i = 2'b11;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (got[i] !== exp_vec(i)) begin
          nmis++;
          $display("FAIL rst_settle_prep dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
        end
      end
      if (en0 && en1) begin done = 1; break; end
    end
    nvec++;
    if (!done) begin nmis++; $display("FAIL rst_settle_prep_timeout: got busy expected idle"); end
    cc_i = 6'h20;
    done = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (got[i] !== exp_vec(i)) begin
          nmis++;
          $display("FAIL rst_settle_apply dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
        end
      end
      if (cc0 == 6'h20) begin done = 1; break; end
    end
    nvec++;
    if (!done) begin nmis++; $display("FAIL rst_settle_apply_timeout: got cc %h expected 20", cc0); end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (got[i] !== rv) begin
        nmis++;
        $display("FAIL rst_async dut%0d: got %h expected %h", i, got[i], rv);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    done = 0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (got[i] !== exp_vec(i)) begin
          nmis++;
          $display("FAIL rst_settle_seq dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
        end
      end
      if (en1 && rise1 < 0) rise1 = k;
      if (en0) begin done = 1; break; end
      low0++;
      @(negedge clk);
    end
    nvec++;
    if (!done) begin nmis++; $display("FAIL rst_settle_timeout: got busy expected idle"); end
    nvec++;
    if (low0 != 129) begin nmis++; $display("FAIL rst_settle_window dut0: got %0d expected 129", low0); end
    nvec++;
    if (rise1 != 3) begin nmis++; $display("FAIL rst_settle_window dut1: got %0d expected 3", rise1); end
    nvec++;
    if (cc0 !== 6'h20 || cc1 !== 6'h20 || upd0 !== 8'd1 || upd1 !== 8'd1) begin
      nmis++;
      $display("FAIL rst_settle_result: got cc %h/%h upd %0d/%0d expected cc 20/20 upd 1/1", cc0, cc1, upd0, upd1);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] u0, u1, p0, p1;
    bit saw0 = 0, saw1 = 0, done;
    u0 = m_upd[0];
    u1 = m_upd[1];
    for (int n = 0; n < 256; n++) begin
      cc_i = cc_i ^ 6'h15;
      done = 0;
      for (int k = 0; k < 200; k++) begin
        p0 = upd0;
        p1 = upd1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          nvec++;
          if (got[i] !== exp_vec(i)) begin
            nmis++;
            $display("FAIL wrap dut%0d t=%0t: got %h expected %h", i, $time, got[i], exp_vec(i));
          end
        end
        if (p0 == 8'hFF && upd0 == 8'h00) saw0 = 1;
        if (p1 == 8'hFF && upd1 == 8'h00) saw1 = 1;
        if (en0 && en1) begin done = 1; break; end
      end
      if (!done) begin
        nvec++; nmis++;
        $display("FAIL wrap_timeout update %0d: got busy expected idle", n);
      end
    end
    nvec++;
    if (upd0 !== u0 || upd1 !== u1) begin
      nmis++; $display("FAIL wrap_count: got %0d/%0d expected %0d/%0d", upd0, upd1, u0, u1);
    end
    nvec++;
    if (!(saw0 && saw1)) begin
      nmis++; $display("FAIL wrap_seen: got %0d/%0d expected 1/1", saw0, saw1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish by 5ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_update();
    test_gate_absorb();
    test_settle_reapply();
    test_random();
    test_reset_in_settle();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
